// File: rtl/bcd_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_pkg (package)
// Purpose  : Shared constants for the multiplexed 7-segment scanner:
//            segment codes for BCD 0-9 and the dash, segment bit indices,
//            the all-off pattern and the a-to-g mask.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_seg_pkg;

  // Active-high segment vector: bit 0 = a ... bit 6 = g, bit 7 = dp
  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg_t SEG_CODE_0 = 8'h3F;
  localparam seg_t SEG_CODE_1 = 8'h06;
  localparam seg_t SEG_CODE_2 = 8'h5B;
  localparam seg_t SEG_CODE_3 = 8'h4F;
  localparam seg_t SEG_CODE_4 = 8'h66;
  localparam seg_t SEG_CODE_5 = 8'h6D;
  localparam seg_t SEG_CODE_6 = 8'h7D;
  localparam seg_t SEG_CODE_7 = 8'h07;
  localparam seg_t SEG_CODE_8 = 8'h7F;
  localparam seg_t SEG_CODE_9 = 8'h6F;
  localparam seg_t SEG_DASH   = 8'h40;

  localparam seg_t SEG_OFF     = 8'h00;
  localparam seg_t SEG_AG_MASK = 8'h7F;

endpackage : bcd_seg_pkg
`default_nettype wire

// File: rtl/bcd_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_scan_if (interface)
// Purpose  : Data/display bundle between the count-latch logic (master) and
//            the display scanner (slave).
// Signals  : load_i  - one-cycle capture strobe for bcd_i/dp_i
//            bcd_i   - packed BCD digits, digit 0 in bits [3:0]
//            dp_i    - decimal point per digit
//            seg_o   - segment bus (a..g, dp), polarity already applied
//            dig_o   - one-hot digit enable, polarity already applied
//            frame_o - one-cycle pulse at the end of a full scan
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_seg_scan_if
  import bcd_seg_pkg::*;
#(
  parameter int DIG_WIDTH = 8
);
  logic                   load_i;
  logic [DIG_WIDTH*4-1:0] bcd_i;
  logic [DIG_WIDTH-1:0]   dp_i;
  seg_t                   seg_o;
  logic [DIG_WIDTH-1:0]   dig_o;
  logic                   frame_o;

  modport master (
    output load_i, bcd_i, dp_i,
    input  seg_o, dig_o, frame_o
  );

  modport slave (
    input  load_i, bcd_i, dp_i,
    output seg_o, dig_o, frame_o
  );
endinterface : bcd_seg_scan_if
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD-to-7-segment decoder, active-high output.
//            Values 10-15 show a dash; dp passes straight to bit 7.
// Ports    : bcd [3:0] in  - digit value
//            dp        in  - decimal point
//            seg [7:0] out - a..g in bits 0..6, dp in bit 7
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_CODE_0;
      4'd1:    seg = SEG_CODE_1;
      4'd2:    seg = SEG_CODE_2;
      4'd3:    seg = SEG_CODE_3;
      4'd4:    seg = SEG_CODE_4;
      4'd5:    seg = SEG_CODE_5;
      4'd6:    seg = SEG_CODE_6;
      4'd7:    seg = SEG_CODE_7;
      4'd8:    seg = SEG_CODE_8;
      4'd9:    seg = SEG_CODE_9;
      default: seg = SEG_DASH;
    endcase
    seg[SEG_DP] = dp;
  end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_scan
// Purpose  : Multiplexed 7-segment display scanner. Holds a tear-free
//            snapshot of the BCD digit vector (updated only at the frame
//            boundary) and time-multiplexes it onto one segment bus with
//            one-hot digit enables and a short blanking gap per slot.
// Ports    : clk           in  - single rising-edge clock
//            rst           in  - asynchronous active-high reset
//            bus (slave)       - load_i/bcd_i/dp_i in, seg_o/dig_o/frame_o out
// Options  : BCD_SCAN_LZB_EN - when defined, leading zeros are blanked
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int DIG_WIDTH      = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
)(
  input  logic          clk,
  input  logic          rst,
  bcd_seg_scan_if.slave bus
);

  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIG_WIDTH > 1) ? $clog2(DIG_WIDTH) : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_BLANK = PCNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIG_WIDTH - 1);

  // XOR masks that turn the active-high internal view into pin polarity
  localparam seg_t                 SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIG_WIDTH-1:0] DIG_POL = (COM_ACTIVE_LOW != 0) ?
                                             {DIG_WIDTH{1'b1}} : {DIG_WIDTH{1'b0}};

  logic [PCNT_W-1:0]      pcnt;
  logic [IDX_W-1:0]       idx;
  logic                   frame_end;

  logic [DIG_WIDTH*4-1:0] pend_bcd;
  logic [DIG_WIDTH-1:0]   pend_dp;
  logic                   pend_v;
  logic [DIG_WIDTH*4-1:0] disp_bcd;
  logic [DIG_WIDTH-1:0]   disp_dp;

  logic [3:0]             cur_bcd;
  logic                   cur_dp;
  seg_t                   cur_seg;
  seg_t                   slot_seg;
  logic [DIG_WIDTH-1:0]   slot_dig;

  assign frame_end = (pcnt == PCNT_LAST) && (idx == IDX_LAST);

  // --------------------------------------------------------------------------
  // Prescaler and digit index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pending / display registers. The display only changes at the frame
  // boundary; a load landing exactly on the boundary bypasses the pending
  // register so it is not delayed by a whole frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else if (frame_end) begin
      if (bus.load_i) begin
        disp_bcd <= bus.bcd_i;
        disp_dp  <= bus.dp_i;
      end else if (pend_v) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
      end
      pend_v <= 1'b0;
    end else if (bus.load_i) begin
      pend_bcd <= bus.bcd_i;
      pend_dp  <= bus.dp_i;
      pend_v   <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit mux and the single shared decoder
  // --------------------------------------------------------------------------
  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIG_WIDTH; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_bcd = disp_bcd[i*4 +: 4];
        cur_dp  = disp_dp[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .dp  (cur_dp),
    .seg (cur_seg)
  );

`ifdef BCD_SCAN_LZB_EN
  // blank[i] is set while every digit from the MSB down to i is zero with
  // no dp; digit 0 is never blanked.
  logic [DIG_WIDTH-1:0] blank;

  always_comb begin : lzb_mask
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int i = DIG_WIDTH - 1; i >= 1; i--) begin
      run      = run && (disp_bcd[i*4 +: 4] == 4'd0) && !disp_dp[i];
      blank[i] = run;
    end
  end

  always_comb begin
    slot_seg = cur_seg;
    for (int i = 0; i < DIG_WIDTH; i++) begin
      if ((idx == IDX_W'(i)) && blank[i]) begin
        slot_seg = cur_seg & ~SEG_AG_MASK;
      end
    end
  end
`else
  assign slot_seg = cur_seg;
`endif

  // Enable stays off for the first BLANK_CYC cycles of each slot so the
  // segment bus settles before the new digit lights.
  assign slot_dig = (pcnt >= PCNT_BLANK) ? (DIG_WIDTH'(1) << idx) : '0;

  // --------------------------------------------------------------------------
  // Output registers with polarity applied
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg_o   <= SEG_OFF ^ SEG_POL;
      bus.dig_o   <= DIG_POL;
      bus.frame_o <= 1'b0;
    end else begin
      bus.seg_o   <= slot_seg ^ SEG_POL;
      bus.dig_o   <= slot_dig ^ DIG_POL;
      bus.frame_o <= frame_end;
    end
  end

endmodule : bcd_seg_scan
`default_nettype wire

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed 7-segment display scanner for the frequency meter. It accepts the packed BCD digit vector produced by the decimal counter chain, holds a tear-free snapshot, and time-multiplexes it onto one shared segment bus with one-hot digit enables. It sits between the count/latch logic and the board's common-anode/cathode display pins.

## Interface
- `DIG_WIDTH`, 8: number of BCD digits; digit 0 is least significant, in `bcd_i[3:0]`.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be at least 2.
- `BLANK_CYC`, 4: cycles at the start of each slot with all digits off (anti-ghosting); must be less than `SCAN_DIV`.
- `SEG_ACTIVE_LOW`, 1: when 1, `seg_o` is inverted.
- `COM_ACTIVE_LOW`, 1: when 1, `dig_o` is inverted.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_i` in 1: one-cycle pulse; capture `bcd_i`/`dp_i` as pending data.
- `bcd_i` in DIG_WIDTH*4: packed BCD digits, 4 bits per digit.
- `dp_i` in DIG_WIDTH: decimal point per digit.
- `seg_o` out 8: segments; bit 0 is a, bits 1 to 6 are b to g, bit 7 is dp.
- `dig_o` out DIG_WIDTH: one-hot digit enable.
- `frame_o` out 1: one-cycle pulse at the last cycle of a full scan.

## Operation
- **Prescaler `pcnt`:** counts 0 to SCAN_DIV-1 and then wraps. At each wrap the digit index `idx` advances 0 to DIG_WIDTH-1 and wraps to 0. The scan order is digit 0 first.
- **Pending register:** `load_i` writes `bcd_i`/`dp_i` into it and sets `pend_v`. A second `load_i` before the frame boundary overwrites it; last write wins.
- **Display register:**
  - It updates only at the frame boundary (`idx`=DIG_WIDTH-1 and `pcnt`=SCAN_DIV-1).
  - If `load_i` is high in that cycle, it takes `bcd_i` directly. Otherwise, if `pend_v` is set, it takes the pending data. `pend_v` then clears.
  - Data therefore never changes mid-frame.
- **Decode:**
  - Nibble values 0 to 9 use the standard codes, active-high: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Nibble values 10 to 15 display "-" (40).
  - dp comes from the display register.
- **Slot output:** during a slot, `dig_o` enables digit `idx` only while `pcnt` ≥ BLANK_CYC and is all-off otherwise. `seg_o` carries the decode of digit `idx` for the whole slot.
- **Polarity:** `SEG_ACTIVE_LOW` and `COM_ACTIVE_LOW` are applied at the output registers.

## Timing
- **Reset values:**
  - `seg_o` all segments off and `dig_o` all off, with polarity applied.
  - `frame_o`=0, `pcnt`=0, `idx`=0, `pend_v`=0.
  - The display register is all zero.
- **Output registers:** all outputs are registered and lag the `pcnt`/`idx` state by one cycle.
- **`frame_o`:** high for exactly one cycle, in the cycle after `pcnt`=SCAN_DIV-1 with `idx`=DIG_WIDTH-1. Its period is DIG_WIDTH*SCAN_DIV cycles.
- **Load-to-display latency:** a `load_i` pulse becomes visible on digit 0 one cycle after the next frame boundary. The worst case is DIG_WIDTH*SCAN_DIV+1 cycles.
- **Reset mid-scan:** the scan restarts at digit 0 with `pcnt`=0. Pending data is discarded.
- **`load_i` during reset:** ignored.

## Configuration
- **`BCD_SCAN_LZB_EN` defined:** leading-zero blanking.
  - Scanning from the MSB downward, digits equal to 0 have segments a to g forced off.
  - Blanking stops at the first nonzero digit, at the first digit with dp set, or at digit 0. Digit 0 is always shown.
  - The blanking mask is computed from the display register.
- **`BCD_SCAN_LZB_EN` not defined:** all digits are shown, including leading zeros. The blanking logic is not present.

## Structure
- **Package `bcd_seg_pkg`:**
  - Segment code constants for 0 to 9 and for the dash.
  - The segment bit-index localparams for a to g and dp.
  - The segment-off constant.
- **Sub-module `bcd_to_seg7`:** combinational 4-bit BCD plus dp in, 8-bit active-high segments out. Instantiate it once on the muxed digit.
- **Top level:** prescaler, index counter, pending and display registers, blanking mask, output polarity registers.

## Test plan
Parameters for all scenarios: DIG_WIDTH=4, SCAN_DIV=8, BLANK_CYC=2, SEG_ACTIVE_LOW=0, COM_ACTIVE_LOW=0.
- **Reset:** assert `rst` mid-slot → `seg_o`=00, `dig_o`=0000 and `frame_o`=0 immediately, without waiting for a clock edge. After release, the first enable is `dig_o`=0001 at `pcnt`=2.
- **Load then scan:**
  - Stimulus: `load_i` with `bcd_i`=0x1234.
  - Next frame, digit 0 slot: `seg_o`=66.
  - Following slots in order: 4F, 5B, 06.
  - `frame_o` pulses every 32 cycles.
- **Tear-free update:** load 0x1111, then load 0x9999 mid-frame → the current frame shows all 06. The next frame shows all 6F.
- **Simultaneous load and boundary:** `load_i` with 0x0005 exactly in the boundary cycle → digit 0 shows 6D in the immediately following frame.
- **Invalid nibble and dp:** `bcd_i`=0x00A0, `dp_i`=0010 → digit 1 shows C0 (dash plus dp).
- **LZB:** with `BCD_SCAN_LZB_EN` defined, `bcd_i`=0x0040 → digits 3 and 2 show 00, digit 1 shows 66, digit 0 shows 3F. With `bcd_i`=0x0000, only digit 0 shows 3F.
